discrete_value_sampler: RTL
===========================

Name: discrete_value_sampler

Overview:
- Downstream stage of the discrete range randomizer in the MCMC constraint solver.
- Consumes the range chosen for one integer variable (start, end, equal) plus a raw random word.
- Produces a uniformly drawn signed value inside [start, end] for the Gibbs/MCMC proposal path.
- Reduction is a multi-cycle shift-subtract modulo (random mod span), so no hardware divider is needed.

Parameters:
- MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, 16, width W of signed variable values and of the range bounds.
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 4, width of the variable index tag.
- RANDOM_WIDTH, 32, width R of the random word; R >= W+1 is required.

Ports:
- in_clock  input  1  single clock; all logic on its rising edge.
- in_reset  input  1  reset, synchronous, active-low.
- in_enable  input  1  request; accepted only when state is IDLE.
- in_variable_index  input  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  tag; captured on accept.
- in_start  input  W signed  range lower bound.
- in_end  input  W signed  range upper bound.
- in_equal  input  1  range is a single point (start==end).
- in_random  input  R  random word; captured on accept.
- out_value  output  W signed  sampled value.
- out_variable_index  output  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  tag of out_value.
- out_valid  output  1  one-cycle pulse; out_value/out_error/index valid with it.
- out_error  output  1  range was empty (start > end, signed); only meaningful with out_valid.
- out_busy  output  1  high while not IDLE.

Behaviour:
- Reset: in_reset==0 at an edge forces state IDLE and clears out_value, out_variable_index, out_valid, out_error, out_busy and all internal registers. Any in-flight request is discarded and produces no out_valid.
- FSM states are IDLE, REDUCE, OUTPUT.
- Accept edge N: state==IDLE and in_enable==1. Capture start, end, index and random. Compute span = end - start + 1 as an unsigned (W+1)-bit value, so a full signed range gives span 2^W.
- Fast path, taken at edge N:
  - If in_equal==1, go to OUTPUT with rem=0. in_equal takes precedence even when start != end; the result is start.
  - Else if start > end (signed), go to OUTPUT with the error flag set and rem=0.
  - out_valid therefore rises at edge N+1.
- Normal path: enter REDUCE with rem=0 and bit counter=R-1.
  - One iteration per edge, MSB first: t = {rem, random[k]}. If t >= span, rem = t - span; else rem = t.
  - The rem register is W+1 bits; t is W+2 bits.
  - Iterations occur at edges N+1..N+R. After the last one, go to OUTPUT.
- OUTPUT, one edge:
  - out_value = start + rem[W-1:0]. The sum fits in W bits because rem < span.
  - out_valid=1, out_error=flag, out_variable_index=tag, state returns to IDLE.
  - Normal-path out_valid rises at edge N+R+1.
- out_valid deasserts at the next edge. out_value and out_variable_index hold until the next OUTPUT.
- out_busy=1 from accept edge N until the edge on which out_valid rises (inclusive of REDUCE and OUTPUT).
- in_enable while not IDLE is ignored; there is no queueing.
- The earliest next accept is the edge after out_valid rises. With in_enable held high, accepts land at N and N+R+2 (normal path), or at N and N+2 (fast path).
- Inputs other than in_enable are don't-care outside the accept edge.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/REDUCE/OUTPUT);
  - width helper constants (span width W+1, counter width clog2(R));
  - the default values of the parameters above.
- One sub-module, sequential_modulo_reducer:
  - start/done handshake; inputs dividend R bits and divisor W+1 bits; output remainder W+1 bits;
  - latency exactly R edges.
- The top level keeps the FSM, range checks and the final add.

Test Plan:
- Point range: start=end=5, in_equal=1, index=3 -> out_valid at N+1, out_value=5, out_error=0, out_variable_index=3.
- Small range: start=-3, end=4, random=0x00000013, R=32 -> span 8, rem 3, out_value=0 at edge N+33, out_busy high N..N+33.
- Full range: start=-32768, end=32767, random=0x00012345 -> span 65536, rem 0x2345, out_value=-23739 at N+33.
- Empty range: start=10, end=2, in_equal=0 -> out_valid and out_error at N+1, out_value=10.
- Mid-operation events:
  - Pulse in_enable with new inputs at N+5 while in REDUCE -> ignored; only the original result appears.
  - Drive in_reset=0 at N+10 -> out_busy=0 after N+10, no out_valid ever for that request.
- Back-to-back: in_enable held high, two normal requests -> accepts at N and N+34, two out_valid pulses at N+33 and N+67 carrying the correct per-request index.

Source files
------------

// File: rtl/discrete_value_sampler_pkg.sv
// rtl/discrete_value_sampler_pkg.sv - shared state encoding, default widths and width helpers
package discrete_value_sampler_pkg;

  localparam int DEF_INT_WIDTH    = 16;
  localparam int DEF_INDEX_WIDTH  = 4;
  localparam int DEF_RANDOM_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // One extra bit so a full signed range has span 2^W.
  function automatic int span_width(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/discrete_value_sampler_reducer.sv
// rtl/discrete_value_sampler_reducer.sv - shift-subtract modulo, one dividend bit per edge, MSB first
module sequential_modulo_reducer
  import discrete_value_sampler_pkg::*;
#(
  parameter int W = DEF_INT_WIDTH,
  parameter int R = DEF_RANDOM_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_start,
  input  logic [R-1:0] i_dividend,
  input  logic [W:0]   i_divisor,
  output logic         o_done,
  output logic [W:0]   o_remainder
);

  localparam int CW = cnt_width(R);

  logic [R-1:0]  r_dividend;
  logic [W:0]    r_divisor;
  logic [W:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_running;

  logic [W+1:0]  w_t;
  logic [W:0]    w_next;

  // rem < divisor keeps t below 2*divisor, so the low W+1 bits of t-divisor are exact.
  always_comb begin
    w_t    = {r_rem, r_dividend[r_cnt]};
    w_next = w_t[W:0];
    if (w_t >= {1'b0, r_divisor}) begin
      w_next = w_t[W:0] - r_divisor;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_running  <= 1'b0;
    end else if (i_start) begin
      r_dividend <= i_dividend;
      r_divisor  <= i_divisor;
      r_rem      <= '0;
      r_cnt      <= CW'(R - 1);
      r_running  <= 1'b1;
    end else if (r_running) begin
      r_rem <= w_next;
      if (r_cnt == '0) begin
        r_running <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Asserted in the cycle whose closing edge performs the final iteration.
  assign o_done      = r_running && (r_cnt == '0);
  assign o_remainder = r_rem;

endmodule

// File: rtl/discrete_value_sampler.sv
// rtl/discrete_value_sampler.sv - draws a uniform signed value in [start, end] from a random word
module discrete_value_sampler
  import discrete_value_sampler_pkg::*;
#(
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = DEF_INT_WIDTH,
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = DEF_INDEX_WIDTH,
  parameter int RANDOM_WIDTH                      = DEF_RANDOM_WIDTH
) (
  input  logic                                               in_clock,
  input  logic                                               in_reset,
  input  logic                                               in_enable,
  input  logic        [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_variable_index,
  input  logic signed [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_start,
  input  logic signed [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_end,
  input  logic                                               in_equal,
  input  logic        [RANDOM_WIDTH-1:0]                      in_random,
  output logic signed [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_value,
  output logic        [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_variable_index,
  output logic                                               out_valid,
  output logic                                               out_error,
  output logic                                               out_busy
);

  localparam int W  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int IW = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int SW = span_width(W);

  state_t          r_state;
  logic [W-1:0]    r_start;
  logic [IW-1:0]   r_tag;
  logic            r_error;
  logic            r_fast;

  logic            w_empty;
  logic [SW-1:0]   w_span;
  logic            w_red_start;
  logic            w_red_done;
  logic [SW-1:0]   w_red_rem;
  logic [W-1:0]    w_rem;

  always_comb begin
    w_empty     = in_end < in_start;
    w_span      = ({in_end[W-1], in_end} - {in_start[W-1], in_start}) + SW'(1);
    w_red_start = (r_state == ST_IDLE) && in_enable && !in_equal && !w_empty;
    w_rem       = r_fast ? '0 : w_red_rem[W-1:0];
  end

  sequential_modulo_reducer #(
    .W (W),
    .R (RANDOM_WIDTH)
  ) u_reducer (
    .i_clk       (in_clock),
    .i_resetn    (in_reset),
    .i_start     (w_red_start),
    .i_dividend  (in_random),
    .i_divisor   (w_span),
    .o_done      (w_red_done),
    .o_remainder (w_red_rem)
  );

  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      r_state            <= ST_IDLE;
      r_start            <= '0;
      r_tag              <= '0;
      r_error            <= 1'b0;
      r_fast             <= 1'b0;
      out_value          <= '0;
      out_variable_index <= '0;
      out_valid          <= 1'b0;
      out_error          <= 1'b0;
      out_busy           <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_enable) begin
            r_start  <= in_start;
            r_tag    <= in_variable_index;
            out_busy <= 1'b1;
            // A point range wins over the empty check even if start != end.
            r_fast   <= in_equal || w_empty;
            r_error  <= !in_equal && w_empty;
            r_state  <= (in_equal || w_empty) ? ST_OUTPUT : ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (w_red_done) begin
            r_state <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          out_value          <= r_start + w_rem;
          out_variable_index <= r_tag;
          out_error          <= r_error;
          out_valid          <= 1'b1;
          out_busy           <= 1'b0;
          r_state            <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
